// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receive path: receiver FSM
//               state encoding, default frame geometry and the parity-select
//               encoding used on the parity_odd input.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default frame geometry
  localparam int c_OVERSAMPLE_DEF = 16;  // baud_tick pulses per bit period
  localparam int c_DATA_BITS_DEF  = 8;   // data bits per frame, LSB first

  // Parity-select encoding on parity_odd
  localparam logic c_PARITY_EVEN = 1'b0;
  localparam logic c_PARITY_ODD  = 1'b1;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/rx_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rx_sync2
// Description : Two-flop synchronizer for the asynchronous serial line. Both
//               flops reset to 1 (line idle level).
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               d_i   - asynchronous input
//               q_o   - synchronized output (two clk latency)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/rx_frame_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rx_frame_controller
// Description : UART receive framer. Detects a start edge, samples each bit
//               at mid-bit using an OVERSAMPLE-rate baud_tick, checks parity
//               and stop bit, and reports each frame with a one-clk rx_valid.
// Ports       : clk          - clock, rising edge
//               reset        - synchronous active-high reset
//               baud_tick    - one-clk strobe at OVERSAMPLE x baud rate
//               rxin         - asynchronous serial line, idle high
//               parity_odd   - 0 even / 1 odd parity, sampled at frame start
//               rxdataout    - received data, held until next rx_valid
//               rx_valid     - one-clk frame-complete pulse
//               parityerror  - parity mismatch on last frame
//               stopbiterror - stop bit sampled low on last frame
//               busy         - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_controller
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = c_OVERSAMPLE_DEF,  // power of two, >= 4
  parameter int DATA_BITS  = c_DATA_BITS_DEF,   // >= 2
  parameter int PARITY_EN  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rxin,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rxdataout,
  output logic                 rx_valid,
  output logic                 parityerror,
  output logic                 stopbiterror,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] c_TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);

  logic line;

  rx_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rxin),
    .q_o   (line)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_odd_q, par_odd_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 wait_high_q, wait_high_d;
  logic                 line_prev_q;
  logic [1:0]           settle_q;
  logic [DATA_BITS-1:0] rxdata_q, rxdata_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 serr_q, serr_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_odd_d   = par_odd_q;
    perr_pend_d = perr_pend_q;
    wait_high_d = wait_high_q;
    rxdata_d    = rxdata_q;
    rx_valid_d  = 1'b0;
    perr_d      = perr_q;
    serr_d      = serr_q;

    case (state_q)
      ST_IDLE: begin
        // The synchronizer flops power up high, so a high line only counts
        // once they have been refilled from rxin; otherwise a line held low
        // through reset would look like a falling edge. The same flag holds
        // off new frames after a break until the line is seen high.
        if (settle_q[1] && line) wait_high_d = 1'b0;
        if (!wait_high_q && line_prev_q && !line) begin
          state_d   = ST_START;
          tick_d    = '0;
          par_odd_d = (parity_odd == c_PARITY_ODD) ? c_PARITY_ODD : c_PARITY_EVEN;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          if (tick_q == c_TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = line ? ST_IDLE : ST_DATA;  // high at mid-bit = glitch
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          tick_d = tick_q + 1'b1;
          // Counter was zeroed at mid-start, so OVERSAMPLE-1 is mid-bit.
          if (tick_q == c_TICK_LAST) begin
            tick_d  = '0;
            shift_d = {line, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == c_BIT_LAST) begin
              bit_d       = '0;
              perr_pend_d = 1'b0;
              state_d     = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == c_TICK_LAST) begin
            tick_d      = '0;
            perr_pend_d = (^shift_q) ^ line ^ par_odd_q;
            state_d     = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == c_TICK_LAST) begin
            tick_d     = '0;
            state_d    = ST_IDLE;
            rx_valid_d = 1'b1;
            perr_d     = (PARITY_EN != 0) ? perr_pend_q : 1'b0;
            if (line) begin
              serr_d   = 1'b0;
              rxdata_d = shift_q;
            end else begin
              serr_d      = 1'b1;
              rxdata_d    = '0;
              wait_high_d = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_odd_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      wait_high_q <= 1'b1;
      line_prev_q <= 1'b1;
      settle_q    <= 2'b00;
      rxdata_q    <= '0;
      rx_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_odd_q   <= par_odd_d;
      perr_pend_q <= perr_pend_d;
      wait_high_q <= wait_high_d;
      line_prev_q <= line;
      settle_q    <= {settle_q[0], 1'b1};
      rxdata_q    <= rxdata_d;
      rx_valid_q  <= rx_valid_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  // Output decode
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  assign rxdataout    = rxdata_q;
  assign rx_valid     = rx_valid_q;
  assign parityerror  = perr_q;
  assign stopbiterror = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_controller
// Description : Self-checking bench for rx_frame_controller. Frames are
//               driven bit-by-bit on rxin; every rx_valid pulse is captured
//               and compared against a frame-level reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_controller;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rxin;
  logic       parity_odd;
  logic [7:0] rxdataout;
  logic       rx_valid;
  logic       parityerror;
  logic       stopbiterror;
  logic       busy;

  rx_frame_controller #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .PARITY_EN  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .rxin         (rxin),
    .parity_odd   (parity_odd),
    .rxdataout    (rxdataout),
    .rx_valid     (rx_valid),
    .parityerror  (parityerror),
    .stopbiterror (stopbiterror),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // baud_tick every tick_div clks (1 = tied high)
  int tick_div = 1;
  initial begin
    int bcnt;
    bcnt      = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      bcnt++;
      if (bcnt >= tick_div) begin
        bcnt      = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } cap_t;

  cap_t vq[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vq.push_back({rxdataout, parityerror, stopbiterror});
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: frame-level rules only.
  function automatic cap_t model(input logic [7:0] d, input logic pb, input logic sb,
                                 input logic odd);
    cap_t r;
    int   ones;
    ones = $countones(d) + int'(pb) + int'(odd);
    r.d  = sb ? d : 8'h00;
    r.pe = (ones % 2) == 1;
    r.se = !sb;
    return r;
  endfunction

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxin = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame_bits(input logic [7:0] d, input logic pb, input logic sb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pb);
    send_bit(sb);
  endtask

  task automatic run_frame(input string pfx, input logic [7:0] d, input logic pb,
                           input logic sb, input logic odd, input cap_t exp,
                           input int idle);
    vq.delete();
    parity_odd = odd;
    send_frame_bits(d, pb, sb);
    if (!sb) repeat (40) @(negedge clk);
    rxin = 1'b1;
    wait_ticks(idle);
    check({pfx, "_valid_cnt"}, vq.size(), 1);
    if (vq.size() > 0) begin
      check({pfx, "_data"}, vq[0].d, exp.d);
      check({pfx, "_perr"}, vq[0].pe, exp.pe);
      check({pfx, "_serr"}, vq[0].se, exp.se);
    end
    check({pfx, "_busy_idle"}, busy, 1'b0);
  endtask

  typedef struct {
    int         div;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic       odd;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  vec_t vecs[7];

  initial begin
    cap_t e;
    vecs[0] = '{1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{2, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{2, 8'h7F, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0};
    vecs[5] = '{3, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};

    // Reset state, with the line held low through reset
    reset      = 1'b1;
    rxin       = 1'b0;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", rxdataout, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_perr", parityerror, 1'b0);
    check("rst_serr", stopbiterror, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    vq.delete();
    repeat (40) @(negedge clk);
    check("low_from_reset_busy", busy, 1'b0);
    check("low_from_reset_valid", vq.size(), 0);
    rxin = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      tick_div = vecs[i].div;
      e.d  = vecs[i].exp_d;
      e.pe = vecs[i].exp_pe;
      e.se = vecs[i].exp_se;
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pb, vecs[i].sb,
                vecs[i].odd, e, 20);
    end

    // Short low glitch: start rejected at mid-bit
    tick_div = 1;
    vq.delete();
    rxin = 1'b0;
    wait_ticks(5);
    rxin = 1'b1;
    check("glitch_busy_during", busy, 1'b1);
    wait_ticks(20);
    check("glitch_busy_after", busy, 1'b0);
    check("glitch_no_valid", vq.size(), 0);

    // Reset during data bit 4 of 0xFF
    vq.delete();
    parity_odd = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxin = 1'b1;
    wait_ticks(8);
    check("midrst_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_data", rxdataout, 8'h00);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_perr", parityerror, 1'b0);
    check("midrst_serr", stopbiterror, 1'b0);
    check("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    wait_ticks(40);
    check("midrst_no_valid", vq.size(), 0);
    e = model(8'h12, 1'b0, 1'b1, 1'b0);
    run_frame("after_rst", 8'h12, 1'b0, 1'b1, 1'b0, e, 20);

    // Back-to-back frames, baud_tick every 3rd clk
    tick_div = 3;
    vq.delete();
    parity_odd = 1'b0;
    send_frame_bits(8'h00, 1'b0, 1'b1);
    send_frame_bits(8'hFF, 1'b0, 1'b1);
    rxin = 1'b1;
    wait_ticks(20);
    check("b2b_valid_cnt", vq.size(), 2);
    if (vq.size() >= 2) begin
      check("b2b0_data", vq[0].d, 8'h00);
      check("b2b0_err", {vq[0].pe, vq[0].se}, 2'b00);
      check("b2b1_data", vq[1].d, 8'hFF);
      check("b2b1_err", {vq[1].pe, vq[1].se}, 2'b00);
    end

    // Randomized frames against the model
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      logic       pb, sb, odd;
      d        = 8'($urandom);
      pb       = 1'($urandom % 2);
      sb       = ($urandom % 5) != 0;
      odd      = 1'($urandom % 2);
      tick_div = int'($urandom_range(1, 3));
      e        = model(d, pb, sb, odd);
      run_frame($sformatf("rand%0d", r), d, pb, sb, odd, e,
                int'($urandom_range(4, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
